sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
// - Shares one like-SRAM port (req/addr_ok/data_ok) between the IF fetch requester (inst) and the EX/MEM load/store requester (data).
// - Sits between the pipeline stages and the unified SRAM/bridge.
// - Selects one request per cycle and records the winner's ID in an in-order outstanding queue.
// - Routes each returning data_ok/rdata to the requester that owns the oldest outstanding transaction.
// PARAMETERS
// - OUTSTANDING  2  max issued-but-unanswered transactions (power of 2, >=1)
// - FAIR_LIMIT   4  consecutive contested data wins before inst is forced to win once (>=1)
// PORTS
// - clk            in   1   clock
// - reset          in   1   reset, synchronous, active-high
// - inst_req       in   1   inst requester request valid
// - inst_addr      in   32  fetch address (always read, size=2'd2)
// - inst_addr_ok   out  1   inst request accepted this cycle
// - inst_data_ok   out  1   inst read data valid
// - inst_rdata     out  32  inst read data
// - data_req       in   1   data requester request valid
// - data_wr        in   1   1=store, 0=load
// - data_size      in   2   0=byte, 1=half, 2=word
// - data_wstrb     in   4   byte write strobes
// - data_addr      in   32  data address
// - data_wdata     in   32  store data
// - data_addr_ok   out  1   data request accepted this cycle
// - data_data_ok   out  1   data response (load data or store ack)
// - data_rdata     out  32  load data
// - sram_req       out  1   request to slave
// - sram_wr        out  1   forwarded wr (0 for inst)
// - sram_size      out  2   forwarded size (2'd2 for inst)
// - sram_wstrb     out  4   forwarded wstrb (4'h0 for inst)
// - sram_addr      out  32  forwarded address
// - sram_wdata     out  32  forwarded wdata (32'h0 for inst)
// - sram_addr_ok   in   1   slave accepted request
// - sram_data_ok   in   1   slave response valid; responses return in issue order
// - sram_rdata     in   32  slave read data
// - arb_err        out  1   1-cycle pulse: sram_data_ok while queue empty
// BEHAVIOUR
// - Grant (combinational):
//   - can_issue = (count != OUTSTANDING); count is registered only.
//   - A pop in the same cycle does NOT free a slot.
//   - Winner is data when data_req, unless inst_req && fair_cnt == FAIR_LIMIT; otherwise inst when inst_req.
// - Request path: sram_req = can_issue && (inst_req || data_req); sram_* carries the winner's fields.
// - Accept:
//   - winner's addr_ok = sram_addr_ok && sram_req; the loser's addr_ok = 0.
//   - Acceptance is the request handshake.
//   - On accept, push the winner ID (ID_INST/ID_DATA) into the queue.
// - Response:
//   - On sram_data_ok with a non-empty queue, pop the head.
//   - Pulse the head owner's *_data_ok for the same cycle.
//   - Both *_rdata = sram_rdata unconditionally.
//   - With an empty queue: drop the response, no *_data_ok, arb_err=1 for that cycle.
// - A response never belongs to a request accepted in the same cycle; push lands at the edge.
// - Simultaneous push and pop: count unchanged, both pointers advance.
// - fair_cnt (0..FAIR_LIMIT):
//   - +1 when data is accepted while inst_req=1.
//   - Cleared when inst is accepted.
//   - Holds otherwise; saturates at FAIR_LIMIT.
// - Requesters hold req/fields stable until addr_ok; the arbiter does not latch request fields.
//   - Zero-latency pass-through.
// - Reset: count, pointers and fair_cnt clear to 0.
//   - All outputs low/zero except *_rdata, which follows sram_rdata.
//   - Reset mid-transaction discards outstanding IDs; late slave responses hit the empty queue and raise arb_err.
// STRUCTURE
// - defination.h:
//   - `ARB_ID_INST 1'b0, `ARB_ID_DATA 1'b1
//   - `SRAM_SIZE_WORD 2'd2
//   - request-bundle width macros shared with the IF/EX/MEM stages
// - Sub-module arb_id_fifo:
//   - Parameterised-depth 1-bit FIFO with push/pop/count and full/empty.
//   - Pointer wrap is modulo OUTSTANDING.
// - Top level holds the grant logic, fair_cnt, and response routing.
// TESTING
// - Inst-only read 0x1c00_0000, slave addr_ok same cycle, data_ok 2 cycles later, rdata 0x3c08_0001 -> inst_data_ok pulse with that rdata; data_data_ok=0.
// - Both req in one cycle (store 0x8000_0010, wstrb 4'hf, wdata 0x1234_5678) -> sram_wr=1, sram_addr=0x8000_0010; data_addr_ok=1, inst_addr_ok=0.
// - OUTSTANDING=2: accept data load then inst fetch with no responses -> sram_req=0 on 3rd cycle; first data_ok -> data_data_ok, second -> inst_data_ok.
// - Contention every cycle with immediate addr_ok and FAIR_LIMIT=4 -> grant pattern D,D,D,D,I repeating.
// - Full queue with data_ok and pending req in the same cycle -> no issue that cycle; issue next cycle.
// - Reset asserted with 2 outstanding, then sram_data_ok -> no *_data_ok, arb_err=1 for one cycle, count stays 0.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared IDs, SRAM encodings and helpers for the SRAM port arbiter
//
// Purpose: common types and constants for the arbiter and its ID FIFO.
//   arb_id_e        owner tag stored per outstanding transaction
//   SRAM_SIZE_WORD  size encoding used for every fetch
//   *_W             request-bundle widths shared with the pipeline stages
package sram_port_arbiter_pkg;

    typedef enum logic {
        ID_INST = 1'b0,
        ID_DATA = 1'b1
    } arb_id_e;

    localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int SIZE_W = 2;

    // A one-entry FIFO still needs a one-bit pointer to keep port widths legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_arb_id_fifo.sv
// rtl/sram_port_arbiter_arb_id_fifo.sv - in-order FIFO of outstanding transaction owner IDs
//
// Purpose: remembers which requester owns each issued-but-unanswered SRAM
// transaction so responses can be routed in issue order.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_id     enqueue an owner ID (ignored when full)
//   pop               dequeue the head (ignored when empty)
//   head_id           owner of the oldest outstanding transaction
//   count             registered occupancy
//   full, empty       occupancy flags derived from count
module arb_id_fifo
    import sram_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         push_id,
    input  logic                         pop,
    output logic                         head_id,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q,    mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH so non-power-of-two depths stay correct.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head_id = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = bump(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = bump(rd_ptr_q);
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one like-SRAM port between the fetch and load/store requesters
//
// Purpose: picks one request per cycle (data preferred, inst forced through
// after FAIR_LIMIT contested data wins), forwards it unlatched to the SRAM
// port, tags it in an in-order ID FIFO and routes each response to its owner.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   inst_req/addr                 fetch request (always word read)
//   inst_addr_ok/data_ok/rdata    fetch accept, response strobe, read data
//   data_req/wr/size/wstrb/addr/wdata  load/store request
//   data_addr_ok/data_ok/rdata    load/store accept, response strobe, read data
//   sram_req/wr/size/wstrb/addr/wdata  forwarded request to the slave
//   sram_addr_ok/data_ok/rdata    slave accept, in-order response, read data
//   arb_err                       response arrived with nothing outstanding
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int FAIR_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata,

    output logic        arb_err
);

    localparam int                FC_W     = $clog2(FAIR_LIMIT + 1);
    localparam int                CNT_W    = $clog2(OUTSTANDING + 1);
    localparam logic [FC_W-1:0]   FAIR_MAX = FC_W'(FAIR_LIMIT);

    logic [FC_W-1:0]  fair_cnt_q, fair_cnt_d;
    logic [CNT_W-1:0] id_count;
    logic             id_full;
    logic             id_empty;
    logic             id_head;
    logic             can_issue;
    logic             data_wins;
    logic             inst_wins;
    logic             accept;
    logic             push;
    logic             push_id;
    logic             pop;

    arb_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_id (push_id),
        .pop     (pop),
        .head_id (id_head),
        .count   (id_count),
        .full    (id_full),
        .empty   (id_empty)
    );

    // Both requesters see the slave data directly; only the data_ok strobes are routed.
    assign inst_rdata = sram_rdata;
    assign data_rdata = sram_rdata;

    always_comb begin
        // Issue depends only on the registered count: a pop this cycle
        // does not open a slot until the next edge.
        can_issue = !id_full;

        // Data normally wins; once inst has lost FAIR_LIMIT contested
        // rounds in a row it is let through once.
        data_wins = data_req && !(inst_req && (fair_cnt_q == FAIR_MAX));
        inst_wins = inst_req && !data_wins;

        sram_req   = !reset && can_issue && (inst_req || data_req);
        sram_wr    = 1'b0;
        sram_size  = '0;
        sram_wstrb = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (sram_req) begin
            if (data_wins) begin
                sram_wr    = data_wr;
                sram_size  = data_size;
                sram_wstrb = data_wstrb;
                sram_addr  = data_addr;
                sram_wdata = data_wdata;
            end else begin
                sram_size  = SRAM_SIZE_WORD;
                sram_addr  = inst_addr;
            end
        end

        accept       = sram_req && sram_addr_ok;
        data_addr_ok = accept && data_wins;
        inst_addr_ok = accept && inst_wins;
        push         = accept;
        push_id      = data_wins ? ID_DATA : ID_INST;

        // The ID for a request accepted this cycle lands at the edge, so a
        // response arriving now always belongs to an older transaction.
        pop          = !reset && sram_data_ok && !id_empty;
        inst_data_ok = pop && (id_head == ID_INST);
        data_data_ok = pop && (id_head == ID_DATA);
        arb_err      = !reset && sram_data_ok && (id_count == '0);

        fair_cnt_d = fair_cnt_q;
        if (inst_addr_ok) begin
            fair_cnt_d = '0;
        end else if (data_addr_ok && inst_req && (fair_cnt_q != FAIR_MAX)) begin
            fair_cnt_d = fair_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fair_cnt_q <= '0;
        end else begin
            fair_cnt_q <= fair_cnt_d;
        end
    end

endmodule
